// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller for the pipelined MIPS CPU.
// Turns the EX/MEM MemRead/MemWrite bits into a req/ack transaction with a
// variable-latency data memory. The pipeline is frozen through stall_o until
// the access completes or times out. Misaligned, conflicting and timed-out
// accesses set a sticky error flag.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 255  // max REQ cycles without ack, 1..255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic        stall_o,
    output logic [31:0] data_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Last value of the wait counter before the access is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       we_q;

    logic op_any;
    logic op_valid;
    logic op_bad;
    logic launch;
    logic ack_hit;
    logic timeout_hit;

    // A legal access is exactly one of read/write to a word-aligned address.
    assign op_any      = MemRead_i | MemWrite_i;
    assign op_valid    = (MemRead_i ^ MemWrite_i) && (addr_i[1:0] == 2'b00);
    assign op_bad      = op_any && !op_valid;
    assign launch      = (state == IDLE) && op_valid;
    assign ack_hit     = (state == REQ) && mem_ack_i;
    assign timeout_hit = (state == REQ) && !mem_ack_i && (cnt == CNT_LAST);

    // State register and wait counter.
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and counter logic; DONE always returns to IDLE so the
    // still-held EX/MEM instruction cannot relaunch.
    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (op_valid) begin
                    state_nxt = REQ;
                    cnt_nxt   = 8'd0;
                end
            end
            REQ: begin
                if (mem_ack_i || (cnt == CNT_LAST)) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request payload is captured at launch and held for the whole REQ phase.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_addr_o  <= 32'd0;
            mem_wdata_o <= 32'd0;
            we_q        <= 1'b0;
        end else if (launch) begin
            mem_addr_o  <= addr_i;
            mem_wdata_o <= data_i;
            we_q        <= MemWrite_i;
        end
    end

    // Load data: captured on a read ack, forced to zero on a read timeout.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_o <= 32'd0;
        end else if (!we_q) begin
            if (ack_hit) begin
                data_o <= mem_rdata_i;
            end else if (timeout_hit) begin
                data_o <= 32'd0;
            end
        end
    end

    // Sticky error: illegal op in IDLE or an abandoned request; only reset clears it.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_o <= 1'b0;
        end else if (((state == IDLE) && op_bad) || timeout_hit) begin
            err_o <= 1'b1;
        end
    end

    // Request is decoded from state only, so it has no path from the inputs.
    assign mem_req_o = (state == REQ);
    assign mem_we_o  = mem_req_o & we_q;

    // Stall is Mealy in IDLE (the launch cycle) and Moore in REQ. The reset
    // term keeps it low while reset is held even if EX/MEM shows a valid op.
    assign stall_o = mem_req_o | (launch & rst_i);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl. Each access is described as a
// transaction (op, address, ack latency); the expected waveform is derived
// from the access timeline: one launch cycle, k+1 request cycles (or TO on
// timeout), one completion cycle. A single negedge process compares every
// DUT output against that expectation each cycle.
module tb_mem_access_ctrl;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        MemRead_i = 1'b0;
    logic        MemWrite_i = 1'b0;
    logic [31:0] addr_i = 32'd0;
    logic [31:0] data_i = 32'd0;
    logic        stall_o;
    logic [31:0] data_o;
    logic        err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'd0;

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .stall_o     (stall_o),
        .data_o      (data_o),
        .err_o       (err_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: architectural registers and this cycle's expected handshake outputs.
    logic [31:0] m_data  = 32'd0;
    logic [31:0] m_addr  = 32'd0;
    logic [31:0] m_wdata = 32'd0;
    logic        m_err   = 1'b0;
    logic        e_stall = 1'b0;
    logic        e_req   = 1'b0;
    logic        e_we    = 1'b0;
    logic        chk_en  = 1'b0;

    int   stall_cnt = 0;
    int   req_cnt   = 0;
    int   req_rises = 0;
    logic req_prev  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk_i) begin
        if (chk_en) begin
            check("stall_o",     {31'd0, stall_o},   {31'd0, e_stall});
            check("mem_req_o",   {31'd0, mem_req_o}, {31'd0, e_req});
            check("mem_we_o",    {31'd0, mem_we_o},  {31'd0, e_we});
            check("mem_addr_o",  mem_addr_o,  m_addr);
            check("mem_wdata_o", mem_wdata_o, m_wdata);
            check("data_o",      data_o,      m_data);
            check("err_o",       {31'd0, err_o},     {31'd0, m_err});
            if (stall_o) stall_cnt++;
            if (mem_req_o) req_cnt++;
            if (mem_req_o && !req_prev) req_rises++;
            req_prev = mem_req_o;
        end
    end

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_idle_inputs();
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
        e_stall    = 1'b0;
        e_req      = 1'b0;
        e_we       = 1'b0;
    endtask

    // One EX/MEM instruction. k in 0..TO-1 acks in request cycle k; k >= TO never acks.
    task automatic do_op(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input int k, input logic [31:0] rdata);
        logic valid;
        valid      = (rd ^ wr) && (a[1:0] == 2'b00);
        stall_cnt  = 0;
        req_cnt    = 0;
        MemRead_i  = rd;
        MemWrite_i = wr;
        addr_i     = a;
        data_i     = d;
        mem_ack_i  = 1'($urandom_range(0, 1));  // stray ack in IDLE is ignored
        mem_rdata_i = $urandom;
        e_stall    = valid;
        e_req      = 1'b0;
        e_we       = 1'b0;
        next_cycle();
        mem_ack_i = 1'b0;
        if (!valid) begin
            if (rd | wr) m_err = 1'b1;
            set_idle_inputs();
            return;
        end
        m_addr  = a;
        m_wdata = d;
        for (int j = 0; j < TO; j++) begin
            e_req       = 1'b1;
            e_we        = wr;
            e_stall     = 1'b1;
            mem_ack_i   = (j == k);
            mem_rdata_i = (j == k) ? rdata : $urandom;
            next_cycle();
            mem_ack_i = 1'b0;
            if (j == k) begin
                if (rd) m_data = rdata;
                break;
            end
            if (j == TO - 1) begin
                m_err = 1'b1;
                if (rd) m_data = 32'd0;
            end
        end
        // Completion cycle: instruction still held in EX/MEM, stray ack possible.
        e_req       = 1'b0;
        e_we        = 1'b0;
        e_stall     = 1'b0;
        mem_ack_i   = 1'($urandom_range(0, 1));
        mem_rdata_i = $urandom;
        next_cycle();
        mem_ack_i = 1'b0;
        set_idle_inputs();
    endtask

    task automatic idle_cycle();
        set_idle_inputs();
        mem_ack_i   = 1'($urandom_range(0, 1));
        mem_rdata_i = $urandom;
        next_cycle();
        mem_ack_i = 1'b0;
    endtask

    // Asynchronous reset pulse between edges; outputs must drop at once.
    task automatic pulse_reset();
        chk_en = 1'b0;
        #2;
        rst_i = 1'b0;
        #1;
        check("rst_req",   {31'd0, mem_req_o}, 32'd0);
        check("rst_stall", {31'd0, stall_o},   32'd0);
        check("rst_err",   {31'd0, err_o},     32'd0);
        next_cycle();
        rst_i   = 1'b1;
        m_data  = 32'd0;
        m_addr  = 32'd0;
        m_wdata = 32'd0;
        m_err   = 1'b0;
        set_idle_inputs();
        req_prev = 1'b0;
        chk_en  = 1'b1;
    endtask

    initial begin
        // Reset state.
        #3;
        check("reset_stall", {31'd0, stall_o},   32'd0);
        check("reset_req",   {31'd0, mem_req_o}, 32'd0);
        check("reset_we",    {31'd0, mem_we_o},  32'd0);
        check("reset_err",   {31'd0, err_o},     32'd0);
        check("reset_data",  data_o,      32'd0);
        check("reset_addr",  mem_addr_o,  32'd0);
        check("reset_wdata", mem_wdata_o, 32'd0);
        next_cycle();
        next_cycle();
        rst_i  = 1'b1;
        chk_en = 1'b1;
        idle_cycle();

        // Read, ack in the first request cycle.
        do_op(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, 32'hDEAD_BEEF);
        check("rd_k0_data",  data_o, 32'hDEAD_BEEF);
        check("rd_k0_req",   req_cnt, 32'd1);
        check("rd_k0_stall", stall_cnt, 32'd2);

        // Write, ack three cycles late; load data untouched.
        do_op(1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, 3, 32'h5555_AAAA);
        check("wr_k3_req",   req_cnt, 32'd4);
        check("wr_k3_stall", stall_cnt, 32'd5);
        check("wr_k3_data",  data_o, 32'hDEAD_BEEF);
        check("wr_k3_addr",  mem_addr_o, 32'h0000_0040);
        check("wr_k3_wdata", mem_wdata_o, 32'h1234_5678);

        // Misaligned read.
        do_op(1'b1, 1'b0, 32'h0000_0042, 32'h0, 0, 32'h0);
        check("misalign_err",   {31'd0, err_o}, 32'd1);
        check("misalign_req",   req_cnt, 32'd0);
        check("misalign_stall", stall_cnt, 32'd0);

        // Reset in the middle of REQ, with the launching op still on the inputs.
        stall_cnt  = 0;
        MemRead_i  = 1'b1;
        MemWrite_i = 1'b0;
        addr_i     = 32'h0000_0100;
        data_i     = 32'h0BAD_0BAD;
        e_stall    = 1'b1;
        next_cycle();
        m_addr  = 32'h0000_0100;
        m_wdata = 32'h0BAD_0BAD;
        e_req   = 1'b1;
        e_we    = 1'b0;
        e_stall = 1'b1;
        pulse_reset();
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hFFFF_FFFF;
        next_cycle();
        mem_ack_i = 1'b0;
        check("post_rst_data", data_o, 32'd0);
        check("post_rst_req",  {31'd0, mem_req_o}, 32'd0);

        // Conflicting read+write.
        do_op(1'b1, 1'b1, 32'h0000_0080, 32'h0, 0, 32'h0);
        check("conflict_err",   {31'd0, err_o}, 32'd1);
        check("conflict_req",   req_cnt, 32'd0);
        check("conflict_stall", stall_cnt, 32'd0);

        // Timeout: preload data_o, then a read that is never acked.
        pulse_reset();
        do_op(1'b1, 1'b0, 32'h0000_0020, 32'h0, 2, 32'hCAFE_F00D);
        check("pre_to_data", data_o, 32'hCAFE_F00D);
        check("pre_to_err",  {31'd0, err_o}, 32'd0);
        do_op(1'b1, 1'b0, 32'h0000_0200, 32'h0, TO, 32'h0);
        check("to_req",   req_cnt, TO);
        check("to_stall", stall_cnt, TO + 1);
        check("to_err",   {31'd0, err_o}, 32'd1);
        check("to_data",  data_o, 32'd0);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h7777_7777;
        next_cycle();
        mem_ack_i = 1'b0;
        check("late_ack_data", data_o, 32'd0);

        // Back-to-back reads, each acked with k = 1.
        req_rises = 0;
        do_op(1'b1, 1'b0, 32'h0000_0300, 32'h0, 1, 32'hA5A5_0001);
        check("b2b_first_data", data_o, 32'hA5A5_0001);
        do_op(1'b1, 1'b0, 32'h0000_0304, 32'h0, 1, 32'hA5A5_0002);
        check("b2b_second_data", data_o, 32'hA5A5_0002);
        check("b2b_launches", req_rises, 32'd2);

        // Randomized traffic against the model.
        for (int t = 0; t < 300; t++) begin
            logic        rd;
            logic        wr;
            logic [31:0] a;
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            if ($urandom_range(0, 9) == 0) pulse_reset();
            do_op(rd, wr, a, $urandom, $urandom_range(0, TO), $urandom);
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end

        idle_cycle();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
